// File: rtl/fib_pkg.sv
// Shared constants and FSM encoding for the Fibonacci write/read-back controller.
package fib_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_FINISH  = 3'd4
  } fib_state_e;

  // A run length is legal when it fits the memory and is non-empty.
  function automatic logic cnt_legal(input logic [CNT_W-1:0] c);
    return (c != '0) && (c <= CNT_W'(DEPTH));
  endfunction

endpackage

// File: rtl/fib_gen_ctrl.sv
// Writes count Fibonacci-style terms into a 16x32 memory, then reads them
// back one word at a time over a valid/ready output port.
module fib_gen_ctrl
  import fib_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow
);

  fib_state_e        state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W:0]   sum_c;
  logic [DATA_W-1:0] term_c;
  logic              first_c;
  logic              carry_c;
  logic              last_c;
  logic [CNT_W-1:0]  k_inc_c;

  // a_q/b_q hold the two terms feeding the next one; on the first step a_q is seed1.
  assign sum_c   = (DATA_W+1)'(a_q) + (DATA_W+1)'(b_q);
  assign first_c = (k_q == '0);
  assign term_c  = first_c ? a_q : sum_c[DATA_W-1:0];
  assign carry_c = !first_c && sum_c[DATA_W];
  assign last_c  = (k_q == cnt_q - CNT_W'(1));
  assign k_inc_c = k_q + CNT_W'(1);

  // Output registers are loaded with the values belonging to the next state.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ovf_d    = ovf_q;
    addr_d   = addr_q;
    wdata_d  = '0;
    wr_d     = 1'b0;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) begin
          if (cnt_legal(count)) begin
            cnt_d   = count;
            a_d     = seed1;
            b_d     = seed0;
            ovf_d   = 1'b0;
            k_d     = '0;
            wr_d    = 1'b1;
            wdata_d = seed0;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (last_c) begin
          k_d     = '0;
          addr_d  = '0;
          state_d = ST_RD_ADDR;
        end else begin
          k_d     = k_inc_c;
          addr_d  = ADDR_W'(k_inc_c);
          wr_d    = 1'b1;
          wdata_d = term_c;
          a_d     = b_q;
          b_d     = term_c;
          ovf_d   = ovf_q | carry_c;
        end
      end
      ST_RD_ADDR: begin
        odata_d  = mem_rdata;
        ovalid_d = 1'b1;
        state_d  = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        ovalid_d = 1'b1;
        if (out_ready) begin
          ovalid_d = 1'b0;
          if (last_c) begin
            k_d     = '0;
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            k_d     = k_inc_c;
            addr_d  = ADDR_W'(k_inc_c);
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_FINISH: begin
        k_d     = '0;
        addr_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        k_d     = '0;
        addr_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = wr_q;
  assign out_data  = odata_q;
  assign out_valid = ovalid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign overflow  = ovf_q;

endmodule
